multicycle_ctrl_fsm: RTL

- Control sequencer for the multicycle CPU datapath.
- Drives the write enables of the PC word latch (pc_wren), the instruction word latch (ir_wren), data memory and the register file, plus the datapath mux selects and the ALU op.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and waits on a memory ready handshake.
- Sits between the instruction register opcode/funct fields and every enabled latch in the datapath.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 68 ++++++
 rtl/multicycle_ctrl_fsm_ctrl_decode.sv | 47 ++++
 rtl/multicycle_ctrl_fsm.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle CPU control sequencer: instruction fields,
// FSM states, ALU op codes and datapath mux select values.
package multicycle_ctrl_fsm_pkg;

   // Instruction opcode field values
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_XOR  = 3'd2;
   localparam logic [2:0] ALU_SLT  = 3'd3;

   localparam logic [1:0] PCSRC_PC4    = 2'd0;
   localparam logic [1:0] PCSRC_BRANCH = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_RS     = 2'd3;

   localparam logic [1:0] ALUB_RT     = 2'd0;
   localparam logic [1:0] ALUB_FOUR   = 2'd1;
   localparam logic [1:0] ALUB_IMM_SE = 2'd2;
   localparam logic [1:0] ALUB_IMM_ZE = 2'd3;

   localparam logic [1:0] RDST_RT  = 2'd0;
   localparam logic [1:0] RDST_RD  = 2'd1;
   localparam logic [1:0] RDST_R31 = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MEM = 2'd1;
   localparam logic [1:0] M2R_PC  = 2'd2;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_EXEC_I    = 4'd3,
      S_WB_ALU    = 4'd4,
      S_MEM_ADDR  = 4'd5,
      S_MEM_READ  = 4'd6,
      S_MEM_WB    = 4'd7,
      S_MEM_WRITE = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_JREG      = 4'd11
   } state_t;

   // Instruction class chosen in DECODE; selects the first execute state
   typedef enum logic [2:0] {
      CLS_ALU_R   = 3'd0,
      CLS_JREG    = 3'd1,
      CLS_MEM     = 3'd2,
      CLS_BRANCH  = 3'd3,
      CLS_ALU_I   = 3'd4,
      CLS_JUMP    = 3'd5,
      CLS_ILLEGAL = 3'd6
   } cls_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// R-type ALU operation and legality flag.
module multicycle_ctrl_fsm_ctrl_decode
   import multicycle_ctrl_fsm_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 3
) (
   input  logic [OPW-1:0]    i_opcode,
   input  logic [OPW-1:0]    i_funct,
   output cls_t              o_cls,
   output logic [ALUOPW-1:0] o_alu_op,
   output logic              o_legal
);

   always_comb begin
      o_cls    = CLS_ILLEGAL;
      o_alu_op = ALUOPW'(ALU_ADD);
      case (i_opcode)
         OPW'(OP_RTYPE): begin
            case (i_funct)
               OPW'(FN_ADD): begin
                  o_cls    = CLS_ALU_R;
                  o_alu_op = ALUOPW'(ALU_ADD);
               end
               OPW'(FN_SUB): begin
                  o_cls    = CLS_ALU_R;
                  o_alu_op = ALUOPW'(ALU_SUB);
               end
               OPW'(FN_SLT): begin
                  o_cls    = CLS_ALU_R;
                  o_alu_op = ALUOPW'(ALU_SLT);
               end
               OPW'(FN_JR):  o_cls = CLS_JREG;
               default:      o_cls = CLS_ILLEGAL;
            endcase
         end
         OPW'(OP_LW), OPW'(OP_SW): o_cls = CLS_MEM;
         OPW'(OP_BNE):             o_cls = CLS_BRANCH;
         OPW'(OP_XORI):            o_cls = CLS_ALU_I;
         OPW'(OP_J), OPW'(OP_JAL): o_cls = CLS_JUMP;
         default:                  o_cls = CLS_ILLEGAL;
      endcase
      o_legal = (o_cls != CLS_ILLEGAL);
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath enables and selects.
module multicycle_ctrl_fsm
   import multicycle_ctrl_fsm_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OPW-1:0]    opcode,
   input  logic [OPW-1:0]    funct,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              pc_wren,
   output logic              ir_wren,
   output logic              mem_wren,
   output logic              reg_wren,
   output logic              iord,
   output logic [1:0]        pc_src,
   output logic [1:0]        alu_src_b,
   output logic [ALUOPW-1:0] alu_op,
   output logic [1:0]        reg_dst,
   output logic [1:0]        mem_to_reg,
   output logic              busy,
   output logic              illegal_op
);

   state_t              r_state;
   state_t              w_next;
   state_t              w_state_eff;
   cls_t                w_cls;
   logic [ALUOPW-1:0]   w_r_alu_op;
   logic                w_legal;

   multicycle_ctrl_fsm_ctrl_decode #(
      .OPW    (OPW),
      .ALUOPW (ALUOPW)
   ) u_decode (
      .i_opcode (opcode),
      .i_funct  (funct),
      .o_cls    (w_cls),
      .o_alu_op (w_r_alu_op),
      .o_legal  (w_legal)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // While reset is high the outputs look like FETCH so the datapath sees a
   // clean idle pattern, and all writes are suppressed below.
   always_comb begin
      w_state_eff = reset ? S_FETCH : r_state;
      w_next      = r_state;
      pc_wren     = 1'b0;
      ir_wren     = 1'b0;
      mem_wren    = 1'b0;
      reg_wren    = 1'b0;
      iord        = 1'b0;
      pc_src      = PCSRC_PC4;
      alu_src_b   = ALUB_RT;
      alu_op      = ALUOPW'(ALU_ADD);
      reg_dst     = RDST_RT;
      mem_to_reg  = M2R_ALU;
      illegal_op  = 1'b0;

      case (w_state_eff)
         S_FETCH: begin
            alu_src_b = ALUB_FOUR;
            if (mem_ready) begin
               ir_wren = 1'b1;
               pc_wren = 1'b1;
               w_next  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = ALUB_IMM_SE;
            if (!w_legal) begin
               illegal_op = 1'b1;
               w_next     = S_FETCH;
            end else begin
               case (w_cls)
                  CLS_ALU_R:  w_next = S_EXEC_R;
                  CLS_JREG:   w_next = S_JREG;
                  CLS_MEM:    w_next = S_MEM_ADDR;
                  CLS_BRANCH: w_next = S_BRANCH;
                  CLS_ALU_I:  w_next = S_EXEC_I;
                  CLS_JUMP:   w_next = S_JUMP;
                  default:    w_next = S_FETCH;
               endcase
            end
         end
         S_EXEC_R: begin
            alu_src_b = ALUB_RT;
            alu_op    = w_r_alu_op;
            w_next    = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_src_b = ALUB_IMM_ZE;
            alu_op    = ALUOPW'(ALU_XOR);
            w_next    = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_wren   = 1'b1;
            mem_to_reg = M2R_ALU;
            reg_dst    = (opcode == OPW'(OP_RTYPE)) ? RDST_RD : RDST_RT;
            w_next     = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_b = ALUB_IMM_SE;
            w_next    = (opcode == OPW'(OP_SW)) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            iord = 1'b1;
            if (mem_ready) w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_wren   = 1'b1;
            mem_to_reg = M2R_MEM;
            reg_dst    = RDST_RT;
            w_next     = S_FETCH;
         end
         S_MEM_WRITE: begin
            iord     = 1'b1;
            mem_wren = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_b = ALUB_RT;
            alu_op    = ALUOPW'(ALU_SUB);
            pc_src    = PCSRC_BRANCH;
            pc_wren   = !zero;
            w_next    = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = PCSRC_JUMP;
            pc_wren = 1'b1;
            // JAL links the PC that FETCH already advanced to PC+4
            if (opcode == OPW'(OP_JAL)) begin
               reg_wren   = 1'b1;
               reg_dst    = RDST_R31;
               mem_to_reg = M2R_PC;
            end
            w_next = S_FETCH;
         end
         S_JREG: begin
            pc_src  = PCSRC_RS;
            pc_wren = 1'b1;
            w_next  = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase

      busy = (w_state_eff != S_FETCH);

      if (reset) begin
         pc_wren    = 1'b0;
         ir_wren    = 1'b0;
         mem_wren   = 1'b0;
         reg_wren   = 1'b0;
         illegal_op = 1'b0;
         w_next     = S_FETCH;
      end
   end

endmodule
